// File: rtl/conv_nav_ctrl.sv
// Navigation controller for the conv2d board demo: button edges step the input/output indices
// and gate valid while conv2d settles. Optional auto-advance via CONV_NAV_AUTOSCAN_EN.
module conv_nav_ctrl #(
    parameter int unsigned NUM_INPUTS    = 4,
    parameter int unsigned OUT_CHANNELS  = 2,
    parameter int unsigned OUT_SIZE      = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SCAN_PERIOD   = 100000000,
    localparam int unsigned IN_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int unsigned CH_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
    localparam int unsigned RC_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            next_in,
    input  logic            prev_in,
    input  logic            next_out,
    input  logic            prev_out,
    output logic [IN_W-1:0] in_idx,
    output logic [CH_W-1:0] ch_idx,
    output logic [RC_W-1:0] row_idx,
    output logic [RC_W-1:0] col_idx,
    output logic            valid,
    output logic            sample
);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0]  IN_MAX     = IN_W'(NUM_INPUTS - 1);
    localparam logic [CH_W-1:0]  CH_MAX     = CH_W'(OUT_CHANNELS - 1);
    localparam logic [RC_W-1:0]  RC_MAX     = RC_W'(OUT_SIZE - 1);

    typedef enum logic {SETTLE, SHOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  in_d;
    logic [CH_W-1:0]  ch_d;
    logic [RC_W-1:0]  row_d, col_d;
    logic             valid_d, sample_d, changed;
    logic             next_in_q, prev_in_q, next_out_q, prev_out_q;
    logic             press_ni, press_pi, press_no, press_po;
    logic             out_fwd, out_bwd, out_wrap;

    assign press_ni = next_in  & ~next_in_q;
    assign press_pi = prev_in  & ~prev_in_q;
    assign press_no = next_out & ~next_out_q;
    assign press_po = prev_out & ~prev_out_q;
    assign out_bwd  = press_po & ~press_no;

`ifdef CONV_NAV_AUTOSCAN_EN
    localparam int unsigned SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              any_press, auto_step;

    assign any_press = press_ni | press_pi | press_no | press_po;
    assign auto_step = (state_q == SHOW) && !any_press && (scan_q == SCAN_W'(SCAN_PERIOD - 1));
    assign out_fwd   = (press_no & ~press_po) | auto_step;
    assign out_wrap  = auto_step;

    // Scan counter only advances while idle in SHOW; a press, an auto step or SETTLE clears it
    assign scan_d = (state_q == SHOW && state_d == SHOW && !any_press) ? SCAN_W'(scan_q + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (reset) scan_q <= '0;
        else       scan_q <= scan_d;
    end
`else
    logic unused_scan_period;

    assign unused_scan_period = (SCAN_PERIOD != 0);
    assign out_fwd  = press_no & ~press_po;
    assign out_wrap = 1'b0;
`endif

    // Index stepping and settle FSM next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_idx;
        ch_d    = ch_idx;
        row_d   = row_idx;
        col_d   = col_idx;

        if (press_ni && !press_pi && in_idx != IN_MAX)   in_d = in_idx + 1'b1;
        else if (press_pi && !press_ni && in_idx != '0)  in_d = in_idx - 1'b1;

        if (out_fwd) begin
            if (col_idx != RC_MAX) begin
                col_d = col_idx + 1'b1;
            end else if (row_idx != RC_MAX) begin
                col_d = '0;
                row_d = row_idx + 1'b1;
            end else if (ch_idx != CH_MAX) begin
                col_d = '0;
                row_d = '0;
                ch_d  = ch_idx + 1'b1;
            end else if (out_wrap) begin
                col_d = '0;
                row_d = '0;
                ch_d  = '0;
            end
        end else if (out_bwd) begin
            if (col_idx != '0) begin
                col_d = col_idx - 1'b1;
            end else if (row_idx != '0) begin
                col_d = RC_MAX;
                row_d = row_idx - 1'b1;
            end else if (ch_idx != '0) begin
                col_d = RC_MAX;
                row_d = RC_MAX;
                ch_d  = ch_idx - 1'b1;
            end
        end

        changed = {in_d, ch_d, row_d, col_d} != {in_idx, ch_idx, row_idx, col_idx};

        case (state_q)
            SETTLE: begin
                if (changed)           cnt_d = CNT_RELOAD;
                else if (cnt_q == '0)  state_d = SHOW;
                else                   cnt_d = cnt_q - 1'b1;
            end
            SHOW: begin
                if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_RELOAD;
                end
            end
            default: state_d = SETTLE;
        endcase

        valid_d  = (state_d == SHOW);
        sample_d = (state_q == SETTLE) && (state_d == SHOW);
    end

    // Prev levels load the live level in reset so a held button cannot fire on release
    always_ff @(posedge clk) begin
        if (reset) begin
            next_in_q  <= next_in;
            prev_in_q  <= prev_in;
            next_out_q <= next_out;
            prev_out_q <= prev_out;
            in_idx     <= '0;
            ch_idx     <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            state_q    <= SETTLE;
            cnt_q      <= CNT_RELOAD;
            valid      <= 1'b0;
            sample     <= 1'b0;
        end else begin
            next_in_q  <= next_in;
            prev_in_q  <= prev_in;
            next_out_q <= next_out;
            prev_out_q <= prev_out;
            in_idx     <= in_d;
            ch_idx     <= ch_d;
            row_idx    <= row_d;
            col_idx    <= col_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid      <= valid_d;
            sample     <= sample_d;
        end
    end
endmodule

// File: tb/tb_conv_nav_ctrl.sv
// Scoreboard bench for conv_nav_ctrl: expected indices queued per press, popped after the step.
module tb_conv_nav_ctrl;
`ifdef CONV_NAV_AUTOSCAN_EN
    localparam int unsigned SP = 8;
`else
    localparam int unsigned SP = 100;
`endif

    typedef struct packed {
        logic [1:0] in;
        logic [0:0] ch;
        logic [1:0] row;
        logic [1:0] col;
    } idx_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic       next_in = 1'b0, prev_in = 1'b0, next_out = 1'b0, prev_out = 1'b0;
    logic [1:0] in_idx, row_idx, col_idx;
    logic [0:0] ch_idx;
    logic       valid, sample;

    idx_t exp_q[$];
    int   n_checks = 0, n_pass = 0;
    int   m_in = 0, m_lin = 0;

    conv_nav_ctrl #(.NUM_INPUTS(4), .OUT_CHANNELS(2), .OUT_SIZE(3), .SETTLE_CYCLES(4),
                    .SCAN_PERIOD(SP)) dut (
        .clk(clk), .reset(reset), .next_in(next_in), .prev_in(prev_in),
        .next_out(next_out), .prev_out(prev_out), .in_idx(in_idx), .ch_idx(ch_idx),
        .row_idx(row_idx), .col_idx(col_idx), .valid(valid), .sample(sample));

    always #5 clk = ~clk;

    function automatic idx_t model_idx();
        idx_t r;
        r.in  = 2'(m_in);
        r.ch  = 1'(m_lin / 9);
        r.row = 2'((m_lin % 9) / 3);
        r.col = 2'(m_lin % 3);
        return r;
    endfunction

    function automatic idx_t dut_idx();
        idx_t r;
        r.in = in_idx; r.ch = ch_idx; r.row = row_idx; r.col = col_idx;
        return r;
    endfunction

    // One-cycle press after a released cycle; returns at the first cycle after the sampling edge
    task automatic press(input logic ni, input logic pi, input logic no, input logic po, output bit chg);
        int old_in = m_in, old_lin = m_lin;
        if (ni != pi) m_in  = ni ? ((m_in < 3) ? m_in + 1 : 3) : ((m_in > 0) ? m_in - 1 : 0);
        if (no != po) m_lin = no ? ((m_lin < 17) ? m_lin + 1 : 17) : ((m_lin > 0) ? m_lin - 1 : 0);
        chg = (m_in != old_in) || (m_lin != old_lin);
        exp_q.push_back(model_idx());
        @(negedge clk);
        next_in = ni; prev_in = pi; next_out = no; prev_out = po;
        @(negedge clk);
        next_in = 1'b0; prev_in = 1'b0; next_out = 1'b0; prev_out = 1'b0;
    endtask

    // Counts cycles (current one = 1) until valid, bounded; records sample there and one cycle later
    task automatic settle(output int k, output logic s1, output logic s2);
        k = 1;
        while (valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        s1 = sample;
        @(negedge clk);
        s2 = sample;
    endtask

    task automatic quiet(output bit ok);
        ok = 1'b1;
        repeat (5) begin
            if (valid !== 1'b1 || sample !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input logic hold_ni);
        @(negedge clk);
        reset = 1'b1; next_in = hold_ni;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_in = 0; m_lin = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        int k; logic s1, s2; idx_t e;
        do_reset(1'b1);
        exp_q.push_back(model_idx());
        n_checks++;
        if ({dut_idx(), valid, sample} !== 9'd0) $display("FAIL reset_state: got %h/%b/%b want 0/0/0", dut_idx(), valid, sample);
        else n_pass++;
        @(negedge clk);
        settle(k, s1, s2);
        n_checks++;
        if (k != 4 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL reset_valid: got k=%0d s=%b%b want k=4 s=10", k, s1, s2);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (dut_idx() !== e) $display("FAIL reset_held_btn: got %h want %h", dut_idx(), e);
        else n_pass++;
        next_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_in_sat();
        int tab[5] = '{1, 2, 3, 3, 3};
        bit chg, ok; int k; logic s1, s2; idx_t e;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 1'b0, 1'b0, chg);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_idx() !== e || int'(in_idx) != tab[i]) $display("FAIL in_sat[%0d]: got %h want %h", i, dut_idx(), e);
            else n_pass++;
            if (chg) begin
                settle(k, s1, s2);
                n_checks++;
                if (k != 5 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL in_sat_valid[%0d]: got k=%0d s=%b%b want k=5 s=10", i, k, s1, s2);
                else n_pass++;
            end else begin
                quiet(ok);
                n_checks++;
                if (!ok) $display("FAIL in_sat_noop[%0d]: valid dropped or sample pulsed, want quiet", i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_out_walk();
        bit chg, ok; int k; logic s1, s2; idx_t e;
        for (int i = 0; i < 19; i++) begin
            if (i < 18) press(1'b0, 1'b0, 1'b1, 1'b0, chg);
            else        press(1'b0, 1'b0, 1'b0, 1'b1, chg);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_idx() !== e) $display("FAIL out_walk[%0d]: got %h want %h", i, dut_idx(), e);
            else n_pass++;
            if (chg) begin
                settle(k, s1, s2);
                n_checks++;
                if (k != 5 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL out_walk_valid[%0d]: got k=%0d s=%b%b want k=5 s=10", i, k, s1, s2);
                else n_pass++;
            end else begin
                quiet(ok);
                n_checks++;
                if (!ok) $display("FAIL out_walk_sat[%0d]: valid dropped or sample pulsed, want quiet", i);
                else n_pass++;
            end
        end
        n_checks++;
        if ({ch_idx, row_idx, col_idx} !== 5'b1_10_01) $display("FAIL out_walk_end: got %b want 11001", {ch_idx, row_idx, col_idx});
        else n_pass++;
    endtask

    task automatic test_borrow();
        bit chg, ok; int k; logic s1, s2; idx_t e;
        for (int i = 0; i < 17; i++) begin
            press(1'b0, 1'b0, 1'b0, 1'b1, chg);
            e = exp_q.pop_front();
            n_checks++;
            if (dut_idx() !== e) $display("FAIL borrow[%0d]: got %h want %h", i, dut_idx(), e);
            else n_pass++;
            if (i == 7) begin
                n_checks++;
                if ({ch_idx, row_idx, col_idx} !== 5'b0_10_10) $display("FAIL borrow_ch: got %b want 01010", {ch_idx, row_idx, col_idx});
                else n_pass++;
            end
            if (chg) begin
                settle(k, s1, s2);
                n_checks++;
                if (k != 5 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL borrow_valid[%0d]: got k=%0d s=%b%b want k=5 s=10", i, k, s1, s2);
                else n_pass++;
            end else begin
                quiet(ok);
                n_checks++;
                if (!ok || {ch_idx, row_idx, col_idx} !== 5'd0) $display("FAIL borrow_floor: idx %h quiet %b want 0 and quiet", dut_idx(), ok);
                else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        bit chg, ok; int k; logic s1, s2; idx_t e;
        press(1'b0, 1'b0, 1'b1, 1'b1, chg);
        e = exp_q.pop_front();
        quiet(ok);
        n_checks++;
        if (dut_idx() !== e || !ok) $display("FAIL simul_out: got %h quiet %b want %h quiet 1", dut_idx(), ok, e);
        else n_pass++;
        press(1'b0, 1'b1, 1'b0, 1'b0, chg);
        e = exp_q.pop_front();
        settle(k, s1, s2);
        press(1'b1, 1'b0, 1'b1, 1'b0, chg);
        e = exp_q.pop_front();
        n_checks++;
        if (dut_idx() !== e || in_idx !== 2'd3 || col_idx !== 2'd1) $display("FAIL simul_in_out: got %h want %h", dut_idx(), e);
        else n_pass++;
        settle(k, s1, s2);
        n_checks++;
        if (k != 5 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL simul_in_out_valid: got k=%0d s=%b%b want k=5 s=10", k, s1, s2);
        else n_pass++;
    endtask

    task automatic test_settle_restart();
        bit chg; int k; logic s1, s2; idx_t e;
        press(1'b0, 1'b0, 1'b1, 1'b0, chg);
        e = exp_q.pop_front();
        n_checks++;
        if (dut_idx() !== e || valid !== 1'b0) $display("FAIL restart_first: got %h v=%b want %h v=0", dut_idx(), valid, e);
        else n_pass++;
        press(1'b0, 1'b0, 1'b1, 1'b0, chg);
        e = exp_q.pop_front();
        n_checks++;
        if (dut_idx() !== e) $display("FAIL restart_second: got %h want %h", dut_idx(), e);
        else n_pass++;
        settle(k, s1, s2);
        n_checks++;
        if (k != 5 || s1 !== 1'b1 || s2 !== 1'b0) $display("FAIL restart_valid: got k=%0d s=%b%b want k=5 s=10", k, s1, s2);
        else n_pass++;
    endtask

    task automatic test_autoscan();
        bit chg; int k; logic s1, s2; idx_t e;
        do_reset(1'b0);
        while (m_lin < 17) begin
            press(1'b0, 1'b0, 1'b1, 1'b0, chg);
            e = exp_q.pop_front();
            settle(k, s1, s2);
            n_checks++;
            if (dut_idx() !== e || k != 5) $display("FAIL scan_walk: got %h k=%0d want %h k=5", dut_idx(), k, e);
            else n_pass++;
        end
        m_lin = 0;
        exp_q.push_back(model_idx());
        k = 0;
        while (({ch_idx, row_idx, col_idx} !== 5'd0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (dut_idx() !== e || k != 7 || valid !== 1'b0) $display("FAIL scan_wrap: got %h k=%0d v=%b want %h k=7 v=0", dut_idx(), k, valid, e);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
`ifdef CONV_NAV_AUTOSCAN_EN
        test_autoscan();
`else
        test_reset();
        test_in_sat();
        test_out_walk();
        test_borrow();
        test_simultaneous();
        test_settle_restart();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
